// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs -- integer ALU reservation station.
//
// Holds NUM_ENT issued ALU instructions. Each entry waits for its source
// operands (snooping the common data bus), and once both are present it is
// a candidate for execution. A round-robin arbiter picks one ready entry,
// computes its result into an output register and offers it on the CDB
// (Breq). The result stays stable until the CDB accepts it (BreqAC), at
// which point the entry is freed.
//
// Ports
//   clk, nRST                  clock, asynchronous active-low reset
//   issue/stnum/ALUop          issue strobe, destination tag, opcode
//   data1/data2, label1/label2 source values and producer tags (0 = valid)
//   use_imm/immd               take zero-extended immd as operand k
//   Busy                       per-entry occupied flags
//   BCEN/BClabel/BCdata        CDB broadcast snooped for wakeup
//   Breq/BreqAC                result offer / acceptance handshake
//   BCLabelOut/BCDataOut       offered tag and result
//
// Opcode encodings (shared with the decoder):
//   0 Addu  1 Subu  2 Add  3 Sub  4 And  5 Or  6 Xor  7 Nor
//   8 Sltu  9 Slt  10 Lui 11 Sll 12 Srl 13 Sra  (others: Vj+Vk)
//
// Build option: define ALU_RS_SHIFT_EN to implement Sll/Srl/Sra. Without it
// the shift opcodes take the default Vj+Vk path and no shifter is built.
// ---------------------------------------------------------------------------
module alu_rs #(
    parameter int NUM_ENT  = 3,
    parameter int DW       = 32,
    parameter int TW       = 5,
    parameter int BASE_TAG = 1
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               issue,
    input  logic [TW-1:0]      stnum,
    input  logic [3:0]         ALUop,
    input  logic [DW-1:0]      data1,
    input  logic [DW-1:0]      data2,
    input  logic [TW-1:0]      label1,
    input  logic [TW-1:0]      label2,
    input  logic               use_imm,
    input  logic [15:0]        immd,
    output logic [NUM_ENT-1:0] Busy,
    input  logic               BCEN,
    input  logic [TW-1:0]      BClabel,
    input  logic [DW-1:0]      BCdata,
    output logic               Breq,
    input  logic               BreqAC,
    output logic [TW-1:0]      BCLabelOut,
    output logic [DW-1:0]      BCDataOut
);

    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_LUI  = 4'd10;
`ifdef ALU_RS_SHIFT_EN
    localparam logic [3:0] OP_SLL  = 4'd11;
    localparam logic [3:0] OP_SRL  = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13;
`endif

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    localparam int IW = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;

    // Entry storage
    logic [NUM_ENT-1:0]         busy_q, busy_d;
    logic [NUM_ENT-1:0][3:0]    op_q,   op_d;
    logic [NUM_ENT-1:0][DW-1:0] vj_q,   vj_d;
    logic [NUM_ENT-1:0][DW-1:0] vk_q,   vk_d;
    logic [NUM_ENT-1:0][TW-1:0] qj_q,   qj_d;
    logic [NUM_ENT-1:0][TW-1:0] qk_q,   qk_d;

    // Output stage
    logic [0:0]    state_q, state_d;
    logic [IW-1:0] rr_q,    rr_d;     // index where the next search starts
    logic [IW-1:0] sel_q,   sel_d;    // entry currently held on the output
    logic [TW-1:0] lab_q,   lab_d;
    logic [DW-1:0] dat_q,   dat_d;

    logic accept;
    logic cdb_hit;
    logic [TW:0] iss_off;
    logic [NUM_ENT-1:0] iss_we, acc_ent, wake_j, wake_k, rdy;

    // Issue operands after immediate select and same-cycle CDB bypass
    logic          byp_j, byp_k;
    logic [DW-1:0] iss_vj, iss_vk;
    logic [TW-1:0] iss_qj, iss_qk;

    assign accept  = (state_q == S_HOLD) && BreqAC;
    assign cdb_hit = BCEN && (BClabel != '0);

    // One extra bit so stnum < BASE_TAG shows up as a negative offset that
    // can never match an entry index.
    assign iss_off = {1'b0, stnum} - (TW+1)'(BASE_TAG);

    assign byp_j  = cdb_hit && (label1 == BClabel);
    assign byp_k  = cdb_hit && (label2 == BClabel);
    assign iss_vj = byp_j ? BCdata : data1;
    assign iss_qj = byp_j ? '0 : label1;
    assign iss_vk = use_imm ? DW'(immd) : (byp_k ? BCdata : data2);
    assign iss_qk = (use_imm || byp_k) ? '0 : label2;

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
        assign acc_ent[g] = accept && (sel_q == IW'(g));
        // A busy entry may be re-issued only in the cycle it is retiring.
        assign iss_we[g]  = issue && (iss_off == (TW+1)'(g)) &&
                            (!busy_q[g] || acc_ent[g]);
        // An entry never wakes on its own tag: that broadcast is its own
        // result retiring, not a producer it waits for.
        assign wake_j[g]  = cdb_hit && busy_q[g] && (qj_q[g] == BClabel) &&
                            (TW'(BASE_TAG + g) != BClabel);
        assign wake_k[g]  = cdb_hit && busy_q[g] && (qk_q[g] == BClabel) &&
                            (TW'(BASE_TAG + g) != BClabel);
        assign rdy[g]     = busy_q[g] && (qj_q[g] == '0) && (qk_q[g] == '0) &&
                            !((state_q == S_HOLD) && (sel_q == IW'(g)));
    end

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (iss_we[i]) begin
                busy_d[i] = 1'b1;
                op_d[i]   = ALUop;
                vj_d[i]   = iss_vj;
                vk_d[i]   = iss_vk;
                qj_d[i]   = iss_qj;
                qk_d[i]   = iss_qk;
            end else if (acc_ent[i]) begin
                busy_d[i] = 1'b0;
                qj_d[i]   = '0;
                qk_d[i]   = '0;
            end else begin
                if (wake_j[i]) begin
                    vj_d[i] = BCdata;
                    qj_d[i] = '0;
                end
                if (wake_k[i]) begin
                    vk_d[i] = BCdata;
                    qk_d[i] = '0;
                end
            end
        end
    end

    // Round-robin pick among ready entries, starting at rr_q
    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   scan;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM_ENT; k++) begin
            scan = {1'b0, rr_q} + (IW+1)'(k);
            if (scan >= (IW+1)'(NUM_ENT)) scan = scan - (IW+1)'(NUM_ENT);
            if (!gnt_vld && rdy[scan[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[IW-1:0];
            end
        end
    end

    // Execute the granted entry
    logic [3:0]    sel_op;
    logic [DW-1:0] sel_vj, sel_vk, alu_res;

    assign sel_op = op_q[gnt_idx];
    assign sel_vj = vj_q[gnt_idx];
    assign sel_vk = vk_q[gnt_idx];

    always_comb begin
        case (sel_op)
            OP_ADDU, OP_ADD: alu_res = sel_vj + sel_vk;
            OP_SUBU, OP_SUB: alu_res = sel_vj - sel_vk;
            OP_AND:  alu_res = sel_vj & sel_vk;
            OP_OR:   alu_res = sel_vj | sel_vk;
            OP_XOR:  alu_res = sel_vj ^ sel_vk;
            OP_NOR:  alu_res = ~(sel_vj | sel_vk);
            OP_SLTU: alu_res = {{(DW-1){1'b0}}, (sel_vj < sel_vk)};
            OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(sel_vj) < $signed(sel_vk))};
            OP_LUI:  alu_res = DW'({sel_vk[15:0], 16'h0000});
`ifdef ALU_RS_SHIFT_EN
            OP_SLL:  alu_res = sel_vk << sel_vj[4:0];
            OP_SRL:  alu_res = sel_vk >> sel_vj[4:0];
            OP_SRA:  alu_res = $signed(sel_vk) >>> sel_vj[4:0];
`endif
            default: alu_res = sel_vj + sel_vk;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        lab_d   = lab_q;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    state_d = S_HOLD;
                    sel_d   = gnt_idx;
                    lab_d   = TW'(BASE_TAG) + TW'(gnt_idx);
                    dat_d   = alu_res;
                    rr_d    = (gnt_idx == IW'(NUM_ENT-1)) ? '0 : gnt_idx + IW'(1);
                end
            end
            S_HOLD: begin
                if (BreqAC) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy_q  <= '0;
            op_q    <= '0;
            vj_q    <= '0;
            vk_q    <= '0;
            qj_q    <= '0;
            qk_q    <= '0;
            state_q <= S_IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            lab_q   <= '0;
            dat_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            lab_q   <= lab_d;
            dat_q   <= dat_d;
        end
    end

    assign Busy       = busy_q;
    assign Breq       = (state_q == S_HOLD);
    assign BCLabelOut = lab_q;
    assign BCDataOut  = dat_q;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;

    localparam logic [3:0] ADDU = 4'd0, SUBU = 4'd1, ADD = 4'd2, SUB = 4'd3;
    localparam logic [3:0] AND_ = 4'd4, OR_ = 4'd5, XOR_ = 4'd6, NOR_ = 4'd7;
    localparam logic [3:0] SLTU = 4'd8, SLT = 4'd9, LUI = 4'd10;
    localparam logic [3:0] SLL = 4'd11, SRA = 4'd13, UNDEF = 4'd15;

    logic        clk = 1'b0;
    logic        nRST, issue, use_imm, BCEN, BreqAC;
    logic [4:0]  stnum, label1, label2, BClabel;
    logic [3:0]  ALUop;
    logic [31:0] data1, data2, BCdata;
    logic [15:0] immd;
    logic [2:0]  Busy;
    logic        Breq;
    logic [4:0]  BCLabelOut;
    logic [31:0] BCDataOut;

    alu_rs dut (
        .clk(clk), .nRST(nRST), .issue(issue), .stnum(stnum), .ALUop(ALUop),
        .data1(data1), .data2(data2), .label1(label1), .label2(label2),
        .use_imm(use_imm), .immd(immd), .Busy(Busy), .BCEN(BCEN),
        .BClabel(BClabel), .BCdata(BCdata), .Breq(Breq), .BreqAC(BreqAC),
        .BCLabelOut(BCLabelOut), .BCDataOut(BCDataOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] t, input logic [3:0] op,
                            input logic [31:0] d1, input logic [4:0] l1,
                            input logic [31:0] d2, input logic [4:0] l2,
                            input logic ui, input logic [15:0] im);
        issue = 1'b1; stnum = t; ALUop = op;
        data1 = d1; label1 = l1; data2 = d2; label2 = l2;
        use_imm = ui; immd = im;
        tick();
        issue = 1'b0; use_imm = 1'b0;
    endtask

    task automatic broadcast(input logic [4:0] t, input logic [31:0] d);
        BCEN = 1'b1; BClabel = t; BCdata = d;
        tick();
        BCEN = 1'b0;
    endtask

    task automatic wait_breq(input string nm, input int max);
        int n = 0;
        while (Breq !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk({nm, "_breq"}, 32'(Breq), 32'd1);
    endtask

    task automatic pop_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, got tag %0h", nm, BCLabelOut);
        end else begin
            e = sb.pop_front();
            chk({nm, "_tag"},  32'(BCLabelOut), 32'(e.tag));
            chk({nm, "_data"}, BCDataOut, e.data);
        end
    endtask

    task automatic accept(input string nm);
        BreqAC = 1'b1;
        tick();
        BreqAC = 1'b0;
        chk({nm, "_drop"}, 32'(Breq), 32'd0);
    endtask

    task automatic drain(input string nm);
        wait_breq(nm, 8);
        pop_check(nm);
        accept(nm);
    endtask

    // Single-op vectors run one at a time
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;
    vec_t vecs[5];

    // Issues entries 1..3 each waiting on tag 20, then wakes all three at once.
    task automatic wave(input logic [31:0] v);
        do_issue(5'd1, ADDU, 32'h0, 5'd20, 32'h1,  5'd0, 1'b0, 16'h0);
        do_issue(5'd2, SUBU, 32'h0, 5'd20, 32'h1,  5'd0, 1'b0, 16'h0);
        do_issue(5'd3, XOR_, 32'h0, 5'd20, 32'hFF, 5'd0, 1'b0, 16'h0);
        chk("wave_busy", 32'(Busy), 32'h7);
        chk("wave_wait", 32'(Breq), 32'd0);
        broadcast(5'd20, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b1; issue = 1'b0; use_imm = 1'b0; BCEN = 1'b0; BreqAC = 1'b0;
        stnum = '0; label1 = '0; label2 = '0; BClabel = '0; ALUop = '0;
        data1 = '0; data2 = '0; BCdata = '0; immd = '0;

        // Reset
        #2 nRST = 1'b0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_breq", 32'(Breq), 32'd0);
        chk("rst_lab",  32'(BCLabelOut), 32'd0);
        chk("rst_dat",  BCDataOut, 32'd0);
        tick(); tick();
        nRST = 1'b1;

        // Basic Addu, two-edge latency
        sb.push_back('{5'd1, 32'd12});
        do_issue(5'd1, ADDU, 32'd5, 5'd0, 32'd7, 5'd0, 1'b0, 16'h0);
        chk("addu_busy", 32'(Busy), 32'h1);
        chk("addu_lat1", 32'(Breq), 32'd0);
        tick();
        chk("addu_lat2", 32'(Breq), 32'd1);
        pop_check("addu");
        accept("addu");
        chk("addu_free", 32'(Busy), 32'h0);

        // Stray acceptance while idle
        BreqAC = 1'b1; tick(); BreqAC = 1'b0;
        chk("stray_ac", 32'(Breq), 32'd0);

        // Sub waiting on tag 9, woken by CDB
        do_issue(5'd2, SUB, 32'h0, 5'd9, 32'd3, 5'd0, 1'b0, 16'h0);
        tick(); tick();
        chk("sub_wait", 32'(Breq), 32'd0);
        chk("sub_busy", 32'(Busy), 32'h2);
        sb.push_back('{5'd2, 32'd7});
        broadcast(5'd9, 32'd10);
        chk("sub_lat1", 32'(Breq), 32'd0);
        tick();
        chk("sub_lat2", 32'(Breq), 32'd1);
        pop_check("sub");
        accept("sub");

        // Zero immediate replaces data2/label2
        sb.push_back('{5'd3, 32'hF0});
        do_issue(5'd3, OR_, 32'hF0, 5'd0, 32'h55, 5'd7, 1'b1, 16'h0000);
        drain("imm0");

        // Lui of immediate
        sb.push_back('{5'd1, 32'hABCD_0000});
        do_issue(5'd1, LUI, 32'h0, 5'd0, 32'h0, 5'd0, 1'b1, 16'hABCD);
        drain("lui");

        // Bypass from CDB in the issue cycle
        sb.push_back('{5'd2, 32'h21});
        BCEN = 1'b1; BClabel = 5'd4; BCdata = 32'h20;
        do_issue(5'd2, ADDU, 32'hDEAD, 5'd4, 32'h1, 5'd0, 1'b0, 16'h0);
        BCEN = 1'b0;
        tick();
        chk("byp_lat", 32'(Breq), 32'd1);
        pop_check("byp");
        accept("byp");

        // Out-of-range and busy-entry issues are ignored; dependency chain
        do_issue(5'd1, ADDU, 32'h0, 5'd3, 32'd10, 5'd0, 1'b0, 16'h0);
        do_issue(5'd0, ADDU, 32'd1, 5'd0, 32'd1, 5'd0, 1'b0, 16'h0);
        do_issue(5'd4, ADDU, 32'd1, 5'd0, 32'd1, 5'd0, 1'b0, 16'h0);
        do_issue(5'd1, ADDU, 32'd100, 5'd0, 32'd100, 5'd0, 1'b0, 16'h0);
        tick();
        chk("oor_busy", 32'(Busy), 32'h1);
        chk("oor_breq", 32'(Breq), 32'd0);
        sb.push_back('{5'd3, 32'hF0F0});
        do_issue(5'd3, XOR_, 32'hFF00, 5'd0, 32'h0FF0, 5'd0, 1'b0, 16'h0);
        drain("dep_prod");
        sb.push_back('{5'd1, 32'hF0FA});
        broadcast(5'd3, 32'hF0F0);
        drain("dep_cons");

        // Assorted ops
        vecs[0] = '{SLT,   32'hFFFF_FFFF, 32'h1, 32'h1};
        vecs[1] = '{SLTU,  32'hFFFF_FFFF, 32'h1, 32'h0};
        vecs[2] = '{NOR_,  32'h0F0F_0000, 32'hFF, 32'hF0F0_FF00};
        vecs[3] = '{UNDEF, 32'hFFFF_FFFF, 32'h2, 32'h1};
        vecs[4] = '{ADD,   32'h7FFF_FFFF, 32'h1, 32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{5'(1 + i % 3), vecs[i].r});
            do_issue(5'(1 + i % 3), vecs[i].op, vecs[i].a, 5'd0, vecs[i].b, 5'd0, 1'b0, 16'h0);
            drain($sformatf("vec%0d", i));
        end

        // Reset while a result is held
        do_issue(5'd2, ADDU, 32'h0, 5'd11, 32'h1, 5'd0, 1'b0, 16'h0);
        do_issue(5'd1, ADDU, 32'd1, 5'd0, 32'd1, 5'd0, 1'b0, 16'h0);
        wait_breq("rsthold", 4);
        #2 nRST = 1'b0;
        #1;
        chk("rsthold_breq", 32'(Breq), 32'd0);
        chk("rsthold_busy", 32'(Busy), 32'd0);
        chk("rsthold_lab",  32'(BCLabelOut), 32'd0);
        tick();
        nRST = 1'b1;
        tick();
        chk("rsthold_after", 32'(Breq), 32'd0);

        // Wave 1: all ready together, pointer at 0 -> 0,1,2
        sb.push_back('{5'd1, 32'h101});
        sb.push_back('{5'd2, 32'hFF});
        sb.push_back('{5'd3, 32'h1FF});
        wave(32'h100);
        wait_breq("w1a", 4);
        pop_check("w1a");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w1_hold_breq", 32'(Breq), 32'd1);
            chk("w1_hold_lab",  32'(BCLabelOut), 32'd1);
            chk("w1_hold_dat",  BCDataOut, 32'h101);
        end
        accept("w1a");
        drain("w1b");
        drain("w1c");

        // Rotate pointer by one, then wave 2 -> 1,2,0
        sb.push_back('{5'd1, 32'd7});
        do_issue(5'd1, OR_, 32'h3, 5'd0, 32'h4, 5'd0, 1'b0, 16'h0);
        drain("rot");
        sb.push_back('{5'd2, 32'h1FF});
        sb.push_back('{5'd3, 32'h2FF});
        sb.push_back('{5'd1, 32'h201});
        wave(32'h200);
        drain("w2a");
        drain("w2b");
        drain("w2c");

        // Shifts (Vj is the shift amount)
`ifdef ALU_RS_SHIFT_EN
        sb.push_back('{5'd1, 32'hF800_0000});
        sb.push_back('{5'd2, 32'h10});
`else
        sb.push_back('{5'd1, 32'h8000_0004});
        sb.push_back('{5'd2, 32'h5});
`endif
        do_issue(5'd1, SRA, 32'd4, 5'd0, 32'h8000_0000, 5'd0, 1'b0, 16'h0);
        drain("sra");
        do_issue(5'd2, SLL, 32'd4, 5'd0, 32'h1, 5'd0, 1'b0, 16'h0);
        drain("sll");

        tick();
        chk("end_busy", 32'(Busy), 32'd0);
        chk("end_breq", 32'(Breq), 32'd0);
        chk("end_sb",   32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
